manchester_decoder: RTL and testbench



---
 rtl/manchester_decoder_if.sv | 35 +++
 rtl/manchester_decoder.sv | 179 +++++++++++++++++
 tb/tb_manchester_decoder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/manchester_decoder_if.sv
// manchester_decoder_if
//   Groups the Manchester receiver's pin-side signals.
//   slave  : the decoder (consumes line_in/dec_en, drives byte and status)
//   master : whatever feeds the line and watches the status pins
// Signals:
//   line_in    serial Manchester line, idles low
//   dec_en     decoder enable
//   data_out   last good byte (DATA_W bits)
//   data_valid one-cycle strobe when data_out updates
//   code_err   one-cycle strobe on an invalid half-bit pair
//   rx_busy    high while a frame is being received
//   parity_err one-cycle strobe on a parity mismatch (MANCHESTER_PARITY_EN only)
interface manchester_decoder_if #(
    parameter int DATA_W = 8
);
    logic              line_in;
    logic              dec_en;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              code_err;
    logic              rx_busy;
`ifdef MANCHESTER_PARITY_EN
    logic              parity_err;

    modport master (output line_in, dec_en,
                    input  data_out, data_valid, code_err, rx_busy, parity_err);
    modport slave  (input  line_in, dec_en,
                    output data_out, data_valid, code_err, rx_busy, parity_err);
`else
    modport master (output line_in, dec_en,
                    input  data_out, data_valid, code_err, rx_busy);
    modport slave  (input  line_in, dec_en,
                    output data_out, data_valid, code_err, rx_busy);
`endif
endinterface

// File: rtl/manchester_decoder.sv
// manchester_decoder
//   Receives a Manchester line (bit 1 = low/high, bit 0 = high/low), locks bit
//   timing to the start bit's mid-bit rising edge and assembles DATA_W-bit
//   bytes, LSB first. No resynchronisation inside a frame.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    manchester_decoder_if.slave (line_in, dec_en in; data_out,
//          data_valid, code_err, rx_busy[, parity_err] out)
// Optional feature (macro MANCHESTER_PARITY_EN): one extra Manchester bit of
//   even parity follows the data; a mismatch pulses parity_err instead of
//   data_valid and leaves data_out untouched.
module manchester_decoder #(
    parameter int HALF_BIT_CYCLES = 4,
    parameter int DATA_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    manchester_decoder_if.slave  bus
);
    localparam int H  = HALF_BIT_CYCLES;
    localparam int CW = $clog2(2 * H);
`ifdef MANCHESTER_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int IW = $clog2(NBITS + 1);

    localparam logic [CW-1:0] CNT_A    = CW'(H / 2);
    localparam logic [CW-1:0] CNT_B    = CW'(H + H / 2);
    localparam logic [CW-1:0] CNT_H    = CW'(H);
    localparam logic [CW-1:0] CNT_MAX  = CW'(2 * H - 1);
    localparam logic [IW-1:0] DATA_IDX = IW'(DATA_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
    logic              a_q, a_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              code_err_q, code_err_d;
    logic              parity_err_q, parity_err_d;

    logic              s2;
    logic              rise;
    logic              wrap;
    logic [CW-1:0]     cnt_inc;

    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[0], bus.line_in};
        prev_d       = sync_q[1];
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        a_d          = a_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        code_err_d   = 1'b0;
        parity_err_d = 1'b0;

        s2      = sync_q[1];
        rise    = sync_q[1] & ~prev_q;
        wrap    = (cnt_q == CNT_MAX);
        cnt_inc = wrap ? '0 : cnt_q + CW'(1);

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // The detected edge is the start bit's mid point.
                if (rise) begin
                    cnt_d   = CNT_H;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_inc;
                if (wrap) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                cnt_d = cnt_inc;
                if (cnt_q == CNT_A) a_d = s2;
                if (cnt_q == CNT_B) begin
                    if (a_q == s2) begin
                        code_err_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        // Right-shift so the first (LSB) bit lands at bit 0.
                        if (bit_idx_q < DATA_IDX) begin
                            shift_d             = shift_q >> 1;
                            shift_d[DATA_W-1]   = s2;
                        end
                        if (bit_idx_q == LAST_IDX) begin
                            // Output registers load on the decision edge so the
                            // strobe appears in STOP's first cycle.
                            state_d = STOP;
`ifdef MANCHESTER_PARITY_EN
                            if (s2 == ^shift_q) begin
                                data_out_d   = shift_q;
                                data_valid_d = 1'b1;
                            end else begin
                                parity_err_d = 1'b1;
                            end
`else
                            data_out_d   = shift_d;
                            data_valid_d = 1'b1;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + IW'(1);
                        end
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_inc;
                if (wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!bus.dec_en) begin
            state_d      = IDLE;
            cnt_d        = '0;
            data_out_d   = data_out_q;
            data_valid_d = 1'b0;
            code_err_d   = 1'b0;
            parity_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            a_q          <= 1'b0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            code_err_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            a_q          <= a_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            code_err_q   <= code_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.code_err   = code_err_q;
    assign bus.rx_busy    = (state_q != IDLE);
`ifdef MANCHESTER_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity = parity_err_q;
`endif
endmodule

// File: tb/tb_manchester_decoder.sv
// tb_manchester_decoder
//   Drives Manchester frames onto line_in and checks the decoder's strobes
//   through a scoreboard. Each frame pushes its predicted outcome (event kind,
//   data_out value, clock edge of the strobe) when it starts; a monitor pops
//   and compares whenever a strobe is seen.
//   Edge numbering: cyc counts posedges; a line level set at a negedge with
//   cyc==n is first captured at edge n+1.
module tb_manchester_decoder;
    localparam int H  = 4;
    localparam int DW = 8;
`ifdef MANCHESTER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int EV_VALID = 1;
    localparam int EV_CODE  = 2;
    localparam int EV_PAR   = 3;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    int   last_good = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;
    int   mon_kind;
    logic perr;

    manchester_decoder_if #(.DATA_W(DW)) bus ();

    manchester_decoder #(.HALF_BIT_CYCLES(H), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef MANCHESTER_PARITY_EN
    assign perr = bus.parity_err;
`else
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Edge at which the strobe for frame bit k appears: the line edge is seen
    // by the FSM two synchroniser edges later, the start bit's second half is
    // H cycles, each bit is 2H, the bit is decided 3H/2 into it, and the
    // strobe is registered one edge after the decision.
    function automatic int ev_cycle(input int e1, input int k);
        return e1 + 3 + H + 2 * H * k + (3 * H) / 2;
    endfunction

    function automatic void push_ev(input int kind, input int data, input int c);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    task automatic half(input int v);
        bus.line_in = (v != 0);
        repeat (H) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * 2 * H) @(negedge clk);
    endtask

    // err_bit >= 0: that bit is held high for both halves and the line is
    // released afterwards. abort_kind 1: drop dec_en after abort_bit;
    // abort_kind 2: assert reset after abort_bit.
    task automatic drive_frame(input int data, input int err_bit, input int bad_par,
                               input int abort_bit, input int abort_kind);
        int e1;
        int nb;
        int b;
        nb = DW + PAR;
        half(0);
        e1 = cyc + 1;
        if (abort_kind == 0) begin
            if (err_bit >= 0)
                push_ev(EV_CODE, last_good, ev_cycle(e1, err_bit));
            else if (PAR != 0 && bad_par != 0)
                push_ev(EV_PAR, last_good, ev_cycle(e1, DW));
            else begin
                push_ev(EV_VALID, data, ev_cycle(e1, nb - 1));
                last_good = data;
            end
        end
        half(1);
        for (int k = 0; k < nb; k++) begin
            if (k < DW) b = (data >> k) & 1;
            else        b = ($countones(data & 255) % 2) ^ bad_par;
            if (k == err_bit) begin
                half(1);
                half(1);
                bus.line_in = 1'b0;
                return;
            end
            half(1 - b);
            half(b);
            if (k == abort_bit) begin
                bus.line_in = 1'b0;
                if (abort_kind == 1) begin
                    bus.dec_en = 1'b0;
                    @(negedge clk);
                    chk("rx_busy_after_disable", int'(bus.rx_busy), 0);
                    chk("data_out_after_disable", int'(bus.data_out), last_good);
                    repeat (2 * H) @(negedge clk);
                    bus.dec_en = 1'b1;
                end else begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_data_out", int'(bus.data_out), 0);
                    chk("rst_rx_busy", int'(bus.rx_busy), 0);
                    chk("rst_strobes", int'(bus.data_valid) + int'(bus.code_err) + int'(perr), 0);
                    last_good = 0;
                    repeat (3) @(negedge clk);
                    rst_n = 1'b1;
                end
                return;
            end
        end
        bus.line_in = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.data_valid || bus.code_err || perr)) begin
            chk("pulse_exclusive", int'(bus.data_valid) + int'(bus.code_err) + int'(perr), 1);
            mon_kind = bus.data_valid ? EV_VALID : (bus.code_err ? EV_CODE : EV_PAR);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", mon_kind, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind", mon_kind, mon_e.kind);
                chk("event_cycle", cyc, mon_e.cyc);
                chk("event_data_out", int'(bus.data_out), mon_e.data);
            end
        end
    end

    initial begin
        int d;
        int eb;
        bus.line_in = 1'b0;
        bus.dec_en  = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data_out", int'(bus.data_out), 0);
        chk("reset_data_valid", int'(bus.data_valid), 0);
        chk("reset_code_err", int'(bus.code_err), 0);
        chk("reset_rx_busy", int'(bus.rx_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        drive_frame(8'hA5, -1, 0, -1, 0);
        idle_bits(2);
        chk("a5_rx_busy_idle", int'(bus.rx_busy), 0);
        chk("a5_data_out", int'(bus.data_out), 8'hA5);

        drive_frame(8'h00, -1, 0, -1, 0);
        idle_bits(2);
        drive_frame(8'hFF, -1, 0, -1, 0);
        idle_bits(2);
        chk("ff_data_out", int'(bus.data_out), 8'hFF);

        drive_frame(8'h3C, 2, 0, -1, 0);
        idle_bits(2);
        chk("after_code_err_data_out", int'(bus.data_out), 8'hFF);
        chk("after_code_err_rx_busy", int'(bus.rx_busy), 0);
        drive_frame(8'h11, -1, 0, -1, 0);
        idle_bits(2);
        chk("11_data_out", int'(bus.data_out), 8'h11);

        drive_frame(8'h5A, -1, 0, 4, 1);
        idle_bits(1);
        drive_frame(8'h5A, -1, 0, -1, 0);
        idle_bits(2);
        chk("5a_data_out", int'(bus.data_out), 8'h5A);

        drive_frame(8'hC3, -1, 0, 3, 2);
        idle_bits(1);
        drive_frame(8'hC3, -1, 0, -1, 0);
        idle_bits(2);
        chk("c3_data_out", int'(bus.data_out), 8'hC3);

`ifdef MANCHESTER_PARITY_EN
        drive_frame(8'h07, -1, 0, -1, 0);
        idle_bits(2);
        chk("par_good_data_out", int'(bus.data_out), 8'h07);
        drive_frame(8'h18, -1, 1, -1, 0);
        idle_bits(2);
        chk("par_bad_data_out", int'(bus.data_out), 8'h07);
        drive_frame(8'h07, -1, 1, -1, 0);
        idle_bits(2);
        chk("par_bad_07_data_out", int'(bus.data_out), 8'h07);
`endif

        for (int i = 0; i < 12; i++) begin
            d  = int'($urandom_range(0, 255));
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW - 1)) : -1;
            drive_frame(d, eb, 0, -1, 0);
            idle_bits(int'($urandom_range(2, 3)));
            chk("rand_data_out", int'(bus.data_out), last_good);
            chk("rand_rx_busy_idle", int'(bus.rx_busy), 0);
        end

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
